// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the shared regfile write port, with a registered output stage.
// Define WB_GRANT_CNT_EN to add per-requester 16-bit grant counters (grant_cnt, cnt_clr).
module regfile_wb_arbiter #(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned DataWidth = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NumReq-1:0]             req_valid,
  output logic [NumReq-1:0]             req_ready,
  input  logic [NumReq*AddrWidth-1:0]   req_rd,
  input  logic [NumReq*DataWidth-1:0]   req_data,
  input  logic                          stall,
  input  logic                          flush,
  output logic [AddrWidth-1:0]          wr_dec_in,
  output logic                          wr_en,
  output logic [DataWidth-1:0]          wr_data,
  output logic [$clog2(NumReq)-1:0]     wr_src
`ifdef WB_GRANT_CNT_EN
  ,
  input  logic                          cnt_clr,
  output logic [NumReq*16-1:0]          grant_cnt
`endif
);

  localparam int unsigned IdxW = $clog2(NumReq);

  logic [IdxW-1:0]      r_ptr;
  logic                 w_gnt_vld;
  logic [IdxW-1:0]      w_gnt_idx;
  logic [AddrWidth-1:0] w_rd;
  logic [DataWidth-1:0] w_data;

  // (base + off) mod NumReq, with both operands below NumReq
  function automatic logic [IdxW-1:0] rr_idx(input logic [IdxW-1:0] base, input int unsigned off);
    logic [IdxW:0] s;
    s = {1'b0, base} + (IdxW+1)'(off);
    if (s >= (IdxW+1)'(NumReq)) s = s - (IdxW+1)'(NumReq);
    return s[IdxW-1:0];
  endfunction

  // First valid requester at or after the pointer wins
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (!rst && !stall) begin
      for (int unsigned k = 0; k < NumReq; k++) begin
        if (!w_gnt_vld && req_valid[rr_idx(r_ptr, k)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = rr_idx(r_ptr, k);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    w_rd      = '0;
    w_data    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (w_gnt_idx == IdxW'(i)) begin
        w_rd   = req_rd[i*AddrWidth +: AddrWidth];
        w_data = req_data[i*DataWidth +: DataWidth];
        if (w_gnt_vld) req_ready[i] = 1'b1;
      end
    end
  end

  // Output stage: one write per grant; x0 and flushed grants are consumed but not written
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      wr_en     <= 1'b0;
      wr_dec_in <= '0;
      wr_data   <= '0;
      wr_src    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (w_gnt_vld) begin
        r_ptr     <= rr_idx(w_gnt_idx, 1);
        wr_dec_in <= w_rd;
        wr_data   <= w_data;
        wr_src    <= w_gnt_idx;
        wr_en     <= (w_rd != '0) && !flush;
      end
    end
  end

`ifdef WB_GRANT_CNT_EN
  logic [NumReq*16-1:0] r_cnt;

  // Counts every completed handshake; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NumReq; i++) begin
        if (req_ready[i]) r_cnt[i*16 +: 16] <= r_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end

  assign grant_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Table-driven bench for regfile_wb_arbiter with a scoreboard queue for the registered write stage.
module tb_regfile_wb_arbiter;
  localparam int unsigned NumReq = 3, AddrWidth = 5, DataWidth = 32;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [2:0]  req_valid, req_ready;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic [4:0]  wr_dec_in;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [1:0]  wr_src;
`ifdef WB_GRANT_CNT_EN
  logic        cnt_clr;
  logic [47:0] grant_cnt;
  logic [15:0] cnt_m [3];
`endif

  regfile_wb_arbiter #(.NumReq(NumReq), .AddrWidth(AddrWidth), .DataWidth(DataWidth)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data), .stall(stall), .flush(flush),
    .wr_dec_in(wr_dec_in), .wr_en(wr_en), .wr_data(wr_data), .wr_src(wr_src)
`ifdef WB_GRANT_CNT_EN
    , .cnt_clr(cnt_clr), .grant_cnt(grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic [2:0]  valid;
    logic [14:0] rd;
    logic [2:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  src;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  exp_t  last;
  int    checks = 0;
  int    failures = 0;
  int    step = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, step, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [2:0] v,
                              input logic [4:0] rd2, input logic [4:0] rd1, input logic [4:0] rd0,
                              input logic [2:0] er);
    vec_t x;
    x.rst = r; x.stall = s; x.flush = f; x.valid = v; x.rd = {rd2, rd1, rd0}; x.exp_ready = er;
    return x;
  endfunction

  // Drive one cycle, check the handshake, queue the expected write, check it after the edge
  task automatic apply(input vec_t v);
    exp_t e;
    logic [95:0] d;
    for (int i = 0; i < 3; i++) d[i*32 +: 32] = {8'hC0 + 8'(i), 8'h00, 16'(step)};
    rst = v.rst; stall = v.stall; flush = v.flush;
    req_valid = v.valid; req_rd = v.rd; req_data = d;
    #1;
    check("req_ready", 64'(req_ready), 64'(v.exp_ready));
    if (v.rst) begin
      e.en = 1'b0; e.rd = '0; e.data = '0; e.src = '0;
      last = e;
    end else if (v.exp_ready != 3'b000) begin
      e.src = 2'd0;
      for (int i = 0; i < 3; i++) if (v.exp_ready[i]) e.src = 2'(i);
      e.rd   = v.rd[e.src*5 +: 5];
      e.data = d[e.src*32 +: 32];
      e.en   = (e.rd != 5'd0) && !v.flush;
      last   = e;
    end else begin
      e = last;
      e.en = 1'b0;
    end
    sb.push_back(e);
`ifdef WB_GRANT_CNT_EN
    for (int i = 0; i < 3; i++) begin
      if (v.rst || cnt_clr) cnt_m[i] = '0;
      else if (v.exp_ready[i]) cnt_m[i] = cnt_m[i] + 16'd1;
    end
`endif
    @(posedge clk); #1;
    e = sb.pop_front();
    check("wr_en", 64'(wr_en), 64'(e.en));
    check("wr_dec_in", 64'(wr_dec_in), 64'(e.rd));
    check("wr_data", 64'(wr_data), 64'(e.data));
    check("wr_src", 64'(wr_src), 64'(e.src));
`ifdef WB_GRANT_CNT_EN
    check("grant_cnt", 64'(grant_cnt), 64'({cnt_m[2], cnt_m[1], cnt_m[0]}));
`endif
    step++;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
`ifdef WB_GRANT_CNT_EN
    cnt_clr = 1'b0;
    for (int i = 0; i < 3; i++) cnt_m[i] = '0;
`endif
    //        rst stall flush valid   rd2   rd1   rd0   ready
    tbl.push_back(mk(1, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000));
    tbl.push_back(mk(1, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 3'b000, 5'd0, 5'd0, 5'd0, 3'b000));
    tbl.push_back(mk(0, 0, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b001));
    tbl.push_back(mk(0, 0, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b010));
    tbl.push_back(mk(0, 0, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b100));
    tbl.push_back(mk(0, 0, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b001));
    tbl.push_back(mk(0, 0, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b010));
    tbl.push_back(mk(0, 0, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b100));
    tbl.push_back(mk(0, 0, 0, 3'b010, 5'd3, 5'd0, 5'd1, 3'b010));
    tbl.push_back(mk(0, 1, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b000));
    tbl.push_back(mk(0, 1, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b000));
    tbl.push_back(mk(0, 1, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b000));
    tbl.push_back(mk(0, 0, 1, 3'b111, 5'd7, 5'd2, 5'd1, 3'b100));
    tbl.push_back(mk(0, 0, 0, 3'b110, 5'd7, 5'd2, 5'd1, 3'b010));
    tbl.push_back(mk(0, 0, 0, 3'b011, 5'd7, 5'd2, 5'd1, 3'b001));
    tbl.push_back(mk(0, 0, 0, 3'b000, 5'd7, 5'd2, 5'd1, 3'b000));
    tbl.push_back(mk(0, 0, 0, 3'b101, 5'd7, 5'd2, 5'd1, 3'b100));
    tbl.push_back(mk(0, 1, 1, 3'b111, 5'd7, 5'd2, 5'd1, 3'b000));
    tbl.push_back(mk(0, 0, 0, 3'b100, 5'd31, 5'd2, 5'd1, 3'b100));
    tbl.push_back(mk(0, 0, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b001));
    tbl.push_back(mk(0, 0, 1, 3'b000, 5'd3, 5'd2, 5'd1, 3'b000));
    // reset mid-stream: rd=9 granted, then reset drops it and returns the pointer to 0
    tbl.push_back(mk(0, 0, 0, 3'b001, 5'd3, 5'd2, 5'd9, 3'b001));
    tbl.push_back(mk(1, 0, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b000));
    tbl.push_back(mk(0, 0, 0, 3'b111, 5'd3, 5'd2, 5'd1, 3'b001));

    @(negedge clk);
    foreach (tbl[k]) apply(tbl[k]);

    // single write with known payload; pointer is 1 so the search wraps to requester 0
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd5}; req_data = {64'h0, 32'hDEADBEEF};
    #1;
    check("single_ready", 64'(req_ready), 64'(3'b001));
    @(posedge clk); #1;
    check("single_wr_en", 64'(wr_en), 64'(1'b1));
    check("single_rd", 64'(wr_dec_in), 64'(5'd5));
    check("single_data", 64'(wr_data), 64'(32'hDEADBEEF));
    check("single_src", 64'(wr_src), 64'(2'd0));
    begin
      logic [31:0] dec;
      dec = 32'd1 << wr_dec_in;
      check("single_decode", 64'(dec), 64'(32'h0000_0020));
    end
`ifdef WB_GRANT_CNT_EN
    cnt_m[0] = cnt_m[0] + 16'd1;
    check("single_cnt", 64'(grant_cnt), 64'({cnt_m[2], cnt_m[1], cnt_m[0]}));
    cnt_clr = 1'b1;
`endif

    // idle cycle: the registered write must not repeat; clear beats a same-cycle grant
`ifdef WB_GRANT_CNT_EN
    req_valid = 3'b001;
`else
    req_valid = 3'b000;
`endif
    @(posedge clk); #1;
    check("no_repeat_wr_en", 64'(wr_en), 64'(1'b1 & req_valid[0] & 1'b1 & (req_rd[4:0] != 5'd0) ? 1'b1 : 1'b0));
`ifdef WB_GRANT_CNT_EN
    check("cnt_clr", 64'(grant_cnt), 64'(0));
    cnt_clr = 1'b0;
`endif
    req_valid = 3'b000;
    @(posedge clk); #1;
    check("idle_wr_en", 64'(wr_en), 64'(1'b0));
    check("idle_hold_rd", 64'(wr_dec_in), 64'(5'd5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
